// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter + 3-step sequencer sharing one pipelined adder among NREQ requesters.
// Latency: request seen in IDLE at edge t -> gnt/EN/S0 in cycle t+1, done pulse in cycle t+4, IDLE in t+5.
// Backpressure: level req held until done; losers simply keep requesting. Build option: ADDER_ARB_FIXED_PRIO_EN.
module adder_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic            EN,
  output logic            S0,
  output logic            S1,
  output logic            S2
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A,
    ST_B,
    ST_C,
    ST_DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] win;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

`ifdef ADDER_ARB_FIXED_PRIO_EN
  // Lowest set request index wins; scanning downwards leaves the lowest one last.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) win = IW'(i);
    end
  end
`else
  logic [IW-1:0] last;

  // Rotating search starting just after the previous winner, wrapping at NREQ.
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    win   = last;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[IW'(idx)]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
  end
`endif

  // Sequencer: state and all outputs registered together so outputs follow state with no decode glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      owner <= '0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
      last  <= IW'(NREQ - 1);
`endif
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      EN    <= 1'b0;
      S0    <= 1'b0;
      S1    <= 1'b0;
      S2    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state <= ST_A;
            owner <= win;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            last  <= win;
`endif
            gnt   <= onehot(win);
            busy  <= 1'b1;
            EN    <= 1'b1;
            S0    <= 1'b1;
          end
        end
        ST_A: begin
          state <= ST_B;
          S0    <= 1'b0;
          S1    <= 1'b1;
        end
        ST_B: begin
          state <= ST_C;
          S2    <= 1'b1;
        end
        ST_C: begin
          state <= ST_DONE;
          EN    <= 1'b0;
          S1    <= 1'b0;
          S2    <= 1'b0;
          done  <= onehot(owner);
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
          done  <= '0;
          busy  <= 1'b0;
          EN    <= 1'b0;
          S0    <= 1'b0;
          S1    <= 1'b0;
          S2    <= 1'b0;
        end
      endcase
    end
  end

endmodule
